// File: rtl/sipo_byte_rx.sv
// sipo_byte_rx: serial-in, parallel-out word receiver.
//
// Assembles a qualified serial bit stream into WIDTH-bit words and presents
// them on a valid/ready output register. A word starts on a bit flagged by
// s_sof. Any later s_sof restarts framing, which discards the partial word.
// A word that completes while the output register is still holding an
// unconsumed word is dropped, and overrun pulses for one cycle.
//
// Optional feature macro: SIPO_PARITY_EN
//   Each word carries WIDTH data bits followed by one even-parity bit.
//   parity_err is registered with m_data.
//   When the macro is not defined, parity_err is constant 0.
//
// Parameters:
//   WIDTH     data word width (>= 2)
//   MSB_FIRST 1: the first received bit lands in m_data[WIDTH-1]
//             0: the first received bit lands in m_data[0]
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   s_valid    serial bit qualifier
//   s_bit      serial data bit
//   s_sof      start-of-word marker, qualified by s_valid
//   m_data     assembled word (registered)
//   m_valid    m_data holds an unconsumed word
//   m_ready    downstream accepts the word this cycle
//   overrun    one-cycle pulse: a completed word was dropped
//   parity_err parity mismatch for the presented word
module sipo_byte_rx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic             s_bit,
  input  logic             s_sof,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT
`ifdef SIPO_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shreg_q;

  logic [WIDTH-1:0] shift_d;    // shift register with s_bit appended
  logic [WIDTH-1:0] first_d;    // shift register restarted with s_bit
  logic             last_bit;
  logic             complete_d;
  logic [WIDTH-1:0] word_d;
  logic             perr_d;
  logic             shreg_unused;

  // The bit that is shifted out is never part of a completed word.
  assign shreg_unused = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  assign shift_d  = MSB_FIRST ? {shreg_q[WIDTH-2:0], s_bit}
                              : {s_bit, shreg_q[WIDTH-1:1]};
  assign first_d  = MSB_FIRST ? {{(WIDTH-1){1'b0}}, s_bit}
                              : {s_bit, {(WIDTH-1){1'b0}}};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Word completion. A bit that carries s_sof never completes a word;
  // it always restarts framing instead.
  always_comb begin
    complete_d = 1'b0;
    word_d     = shift_d;
    perr_d     = 1'b0;
    if (s_valid && !s_sof) begin
      case (state_q)
`ifdef SIPO_PARITY_EN
        S_PARITY: begin
          complete_d = 1'b1;
          word_d     = shreg_q;
          perr_d     = ^{shreg_q, s_bit};
        end
`else
        S_SHIFT: complete_d = last_bit;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      overrun <= 1'b0;

      // Framing
      if (s_valid) begin
        if (s_sof) begin
          shreg_q <= first_d;
          cnt_q   <= CW'(1);
          state_q <= S_SHIFT;
        end else begin
          case (state_q)
            S_SHIFT: begin
              shreg_q <= shift_d;
              if (last_bit) begin
                cnt_q   <= '0;
`ifdef SIPO_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_IDLE;
`endif
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
`ifdef SIPO_PARITY_EN
            S_PARITY: state_q <= S_IDLE;
`endif
            default: ;
          endcase
        end
      end

      // Output register. A completion may load in the same cycle that the
      // current word transfers.
      if (complete_d) begin
        if (!m_valid || m_ready) begin
          m_data     <= word_d;
          parity_err <= perr_d;
          m_valid    <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_byte_rx.sv
module tb_sipo_byte_rx;

  localparam int W = 8;
`ifdef SIPO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0, s_bit = 1'b0, s_sof = 1'b0, m_ready = 1'b0;
  logic [W-1:0] data_m, data_l;
  logic valid_m, valid_l, ovr_m, ovr_l, perr_m, perr_l;

  always #5 clk = ~clk;

  sipo_byte_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_bit(s_bit), .s_sof(s_sof),
    .m_data(data_m), .m_valid(valid_m), .m_ready(m_ready),
    .overrun(ovr_m), .parity_err(perr_m));

  sipo_byte_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_bit(s_bit), .s_sof(s_sof),
    .m_data(data_l), .m_valid(valid_l), .m_ready(m_ready),
    .overrun(ovr_l), .parity_err(perr_l));

  typedef struct { logic [W-1:0] d; logic pe; } exp_t;
  exp_t q_m[$];
  exp_t q_l[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit           bits[$];
  bit           in_word = 1'b0;
  bit           started = 1'b0;
  logic         exp_valid = 1'b0, exp_ovr = 1'b0, exp_pe = 1'b0;
  logic [W-1:0] exp_dm = '0, exp_dl = '0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: collect the bits of the current frame, then build each word
  // from its bit list with plain indexing.
  always @(posedge clk) begin : model
    logic [W-1:0] wm, wl;
    bit pe, done;
    if (rst) begin
      bits.delete();
      in_word   = 1'b0;
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      exp_pe    = 1'b0;
      exp_dm    = '0;
      exp_dl    = '0;
      q_m.delete();
      q_l.delete();
      started   = 1'b1;
    end else begin
      exp_ovr = 1'b0;
      done    = 1'b0;
      wm = '0; wl = '0; pe = 1'b0;
      if (s_valid) begin
        if (s_sof) begin
          bits.delete();
          bits.push_back(s_bit);
          in_word = 1'b1;
        end else if (in_word) begin
          bits.push_back(s_bit);
        end
      end
      if (in_word && bits.size() == W + PAR) begin
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = bits[i];
          wl[i]     = bits[i];
          pe        = pe ^ bits[i];
        end
        if (PAR == 1) pe = pe ^ bits[W];
        else          pe = 1'b0;
        done    = 1'b1;
        in_word = 1'b0;
        bits.delete();
      end
      if (done) begin
        if (!exp_valid || m_ready) begin
          exp_valid = 1'b1;
          exp_dm    = wm;
          exp_dl    = wl;
          exp_pe    = pe;
          q_m.push_back('{d: wm, pe: pe});
          q_l.push_back('{d: wl, pe: pe});
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (exp_valid && m_ready) begin
        exp_valid = 1'b0;
      end
    end
  end

  // Monitor: sampled mid-cycle; a transfer is m_valid & m_ready before the next edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (started) begin
      check("valid_msb", valid_m, exp_valid);
      check("valid_lsb", valid_l, exp_valid);
      check("overrun_msb", ovr_m, exp_ovr);
      check("overrun_lsb", ovr_l, exp_ovr);
      check("data_hold_msb", data_m, exp_dm);
      check("data_hold_lsb", data_l, exp_dl);
      check("perr_msb", perr_m, exp_pe);
      check("perr_lsb", perr_l, exp_pe);
      if (valid_m && m_ready) begin
        n_checks++;
        if (q_m.size() == 0) begin
          n_fail++;
          $display("FAIL sb_msb: got word %0h, expected none", data_m);
        end else begin
          e = q_m.pop_front();
          check("sb_data_msb", data_m, e.d);
          check("sb_perr_msb", perr_m, e.pe);
        end
      end
      if (valid_l && m_ready) begin
        n_checks++;
        if (q_l.size() == 0) begin
          n_fail++;
          $display("FAIL sb_lsb: got word %0h, expected none", data_l);
        end else begin
          e = q_l.pop_front();
          check("sb_data_lsb", data_l, e.d);
          check("sb_perr_lsb", perr_l, e.pe);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic b, input logic sof);
    s_valid = v; s_bit = b; s_sof = sof;
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  // Sends val most-significant bit first; the parity bit is appended when enabled.
  task automatic send_word(input logic [W-1:0] val, input bit par_ok);
    for (int i = 0; i < W; i++) cyc(1'b1, val[W-1-i], (i == 0));
    if (PAR == 1) cyc(1'b1, (^val) ^ !par_ok, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Basic word, both bit orders (0xC0 / 0x03)
    m_ready = 1'b1;
    send_word(8'hC0, 1'b1);
    idle(3);

    // Resync after a partial word
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    send_word(8'h5A, 1'b1);
    idle(3);

    // Backpressure: the second word is dropped with an overrun pulse
    m_ready = 1'b0;
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b1);
    idle(3);
    m_ready = 1'b1;
    idle(3);

    // Reset mid-word, then bits without s_sof
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < W; i++) cyc(1'b1, 1'b1, 1'b0);
    idle(2);
    send_word(8'h96, 1'b1);
    idle(2);

    // Good and bad parity on 0x01
    send_word(8'h01, 1'b1);
    idle(1);
    send_word(8'h01, 1'b0);
    idle(2);

    // Random framed words, back-to-back or with gaps
    for (int k = 0; k < 150; k++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      send_word(W'($urandom), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
    end

    // Fully random serial traffic
    for (int k = 0; k < 4000; k++) begin
      m_ready = ($urandom_range(0, 9) < 7);
      cyc(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 11) == 0));
    end

    m_ready = 1'b1;
    idle(5);
    check("drain_msb", W'(q_m.size()), '0);
    check("drain_lsb", W'(q_l.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
